// File: rtl/fe_pkg.sv
// Shared types for the RV32I handshake control unit: FSM states, trap
// causes, decoder opcode classes and mnemonics, plus small opcode/mnemonic
// classifiers used by the FSM.
package fe_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } RV32I_CU_STATE_t;

  typedef enum logic [2:0] {
    TC_NONE          = 3'd0,
    TC_ILLEGAL       = 3'd1,
    TC_ECALL         = 3'd2,
    TC_FETCH_TIMEOUT = 3'd3,
    TC_MEM_TIMEOUT   = 3'd4
  } RV32I_TRAP_CAUSE_t;

  // Opcode classes as produced by the decoder. JALR has its own class
  // because it shares the I-format but behaves as a control transfer.
  typedef enum logic [3:0] {
    R_TYPE       = 4'd0,
    I_TYPE       = 4'd1,
    I_LOAD_TYPE  = 4'd2,
    I_JALR_TYPE  = 4'd3,
    I_FENCE_TYPE = 4'd4,
    I_ENV_TYPE   = 4'd5,
    S_TYPE       = 4'd6,
    B_TYPE       = 4'd7,
    J_TYPE       = 4'd8,
    U_LUI_TYPE   = 4'd9,
    U_AUI_TYPE   = 4'd10,
    INVALID_TYPE = 4'd15
  } RV32I_OPCODE_t;

  typedef enum logic [5:0] {
    MN_INVALID, MN_LUI, MN_AUIPC, MN_JAL, MN_JALR,
    MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU,
    MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU,
    MN_SB, MN_SH, MN_SW,
    MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI, MN_ANDI,
    MN_SLLI, MN_SRLI, MN_SRAI,
    MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU, MN_XOR, MN_SRL, MN_SRA,
    MN_OR, MN_AND,
    MN_FENCE, MN_ECALL, MN_EBREAK
  } RV32I_INSTRUCTION_MNEMONIC_t;

  // Instruction needs a data bus access after EXECUTE.
  function automatic logic is_mem_op(input RV32I_OPCODE_t op);
    return (op == I_LOAD_TYPE) || (op == S_TYPE);
  endfunction

  // Instruction updates the PC directly from EXECUTE (no WRITEBACK).
  function automatic logic is_flow_op(input RV32I_OPCODE_t op);
    return (op == B_TYPE) || (op == J_TYPE) || (op == I_JALR_TYPE) || (op == U_AUI_TYPE);
  endfunction

  // Control transfers that also write rd in EXECUTE.
  function automatic logic links_in_execute(input RV32I_INSTRUCTION_MNEMONIC_t mn);
    return (mn == MN_JAL) || (mn == MN_JALR) || (mn == MN_AUIPC);
  endfunction

  // Instructions whose result is written to rd in WRITEBACK.
  function automatic logic writes_rd_in_wb(input RV32I_OPCODE_t op);
    return (op == R_TYPE) || (op == I_TYPE) || (op == I_LOAD_TYPE) || (op == U_LUI_TYPE);
  endfunction

endpackage

// File: rtl/cu_bus_timeout.sv
// Bus access watchdog. Counts cycles spent waiting for an acknowledge and
// flags expiry on the last allowed waiting cycle. BUS_TIMEOUT = 0 disables
// expiry entirely (the counter then simply wraps).
module cu_bus_timeout #(
  parameter int BUS_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LP_LAST = (BUS_TIMEOUT > 0) ? TO_W'(BUS_TIMEOUT - 1) : '0;

  logic [TO_W-1:0] r_count;

  // Wait counter: clear has priority, otherwise count while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  // A clear in the expiring cycle (acknowledge) suppresses the timeout.
  assign o_expired = (BUS_TIMEOUT > 0) && i_enable && !i_clear && (r_count == LP_LAST);

endmodule

// File: rtl/rv32i_hs_control_unit.sv
// Multi-cycle RV32I control FSM with bus and execute handshakes.
// Optional performance counters are built when RV32I_CU_PERF_CNT_EN is
// defined; otherwise perf_cycles/perf_instret do not exist.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | out of reset, nothing issued
//   FETCH     | instruction read on the bus, waiting for bus_ack
//   DECODE    | decoder output checked: illegal or ECALL/EBREAK traps
//   EXECUTE   | ALU working; held while exec_busy; flow ops update PC
//   MEM       | load/store on the bus, strobes stable until bus_ack
//   WRITEBACK | rd written (if any) and PC advanced
//   TRAP      | one cycle: PC loaded from trap vector, cause latched
module rv32i_hs_control_unit
  import fe_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
`ifdef RV32I_CU_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  RV32I_OPCODE_t               opcode,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic                        opcode_legal,
  input  logic                        bus_ack,
  input  logic                        exec_busy,
  output logic                        bus_req,
  output logic                        bus_rden,
  output logic                        bus_wren,
  output logic                        bus_addr_select_alu_out,
  output logic                        ir_wren,
  output logic                        rf_wren,
  output logic                        program_counter_wren,
  output logic                        pc_select_trap,
  output logic                        trap_valid,
  output RV32I_TRAP_CAUSE_t           trap_cause,
  output RV32I_CU_STATE_t             control_unit_state,
  output RV32I_CU_STATE_t             control_unit_state_next
`ifdef RV32I_CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]            perf_cycles,
  output logic [CNT_W-1:0]            perf_instret
`endif
);

  localparam int TO_W = (BUS_TIMEOUT > 0) ? (($clog2(BUS_TIMEOUT + 1) > 0) ? $clog2(BUS_TIMEOUT + 1) : 1) : 1;

  RV32I_CU_STATE_t   r_state;
  RV32I_CU_STATE_t   w_state_next;
  RV32I_TRAP_CAUSE_t r_trap_cause;
  RV32I_TRAP_CAUSE_t w_trap_cause_next;
  logic              r_mem_store;
  logic              w_waiting;
  logic              w_timeout;

  assign w_waiting = (r_state == FETCH) || (r_state == MEM);

  // The counter sits at zero outside FETCH/MEM, so every access starts
  // from a fresh count without a separate entry pulse.
  cu_bus_timeout #(
    .BUS_TIMEOUT (BUS_TIMEOUT),
    .TO_W        (TO_W)
  ) u_bus_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_waiting || bus_ack),
    .i_enable  (w_waiting),
    .o_expired (w_timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Trap cause is captured on the way into TRAP and held until the next trap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trap_cause <= TC_NONE;
    end else if (w_state_next == TRAP) begin
      r_trap_cause <= w_trap_cause_next;
    end
  end

  // Access direction is frozen when MEM is entered so the strobes cannot
  // move while the bus is still working on the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_store <= 1'b0;
    end else if ((r_state == EXECUTE) && (w_state_next == MEM)) begin
      r_mem_store <= (opcode == S_TYPE);
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    w_state_next            = r_state;
    w_trap_cause_next       = TC_NONE;
    bus_req                 = 1'b0;
    bus_rden                = 1'b0;
    bus_wren                = 1'b0;
    bus_addr_select_alu_out = 1'b0;
    ir_wren                 = 1'b0;
    rf_wren                 = 1'b0;
    program_counter_wren    = 1'b0;
    pc_select_trap          = 1'b0;
    trap_valid              = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        bus_req  = 1'b1;
        bus_rden = 1'b1;
        if (bus_ack) begin
          ir_wren      = 1'b1;
          w_state_next = DECODE;
        end else if (w_timeout) begin
          w_state_next      = TRAP;
          w_trap_cause_next = TC_FETCH_TIMEOUT;
        end
      end
      DECODE: begin
        if (!opcode_legal) begin
          w_state_next      = TRAP;
          w_trap_cause_next = TC_ILLEGAL;
        end else if (opcode == I_ENV_TYPE) begin
          w_state_next      = TRAP;
          w_trap_cause_next = TC_ECALL;
        end else begin
          w_state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        if (!exec_busy) begin
          if (is_mem_op(opcode)) begin
            w_state_next = MEM;
          end else if (is_flow_op(opcode)) begin
            program_counter_wren = 1'b1;
            rf_wren              = links_in_execute(mnemonic);
            w_state_next         = FETCH;
          end else begin
            w_state_next = WRITEBACK;
          end
        end
      end
      MEM: begin
        bus_req                 = 1'b1;
        bus_addr_select_alu_out = 1'b1;
        bus_rden                = !r_mem_store;
        bus_wren                = r_mem_store;
        if (bus_ack) begin
          if (r_mem_store) begin
            program_counter_wren = 1'b1;
            w_state_next         = FETCH;
          end else begin
            w_state_next = WRITEBACK;
          end
        end else if (w_timeout) begin
          w_state_next      = TRAP;
          w_trap_cause_next = TC_MEM_TIMEOUT;
        end
      end
      WRITEBACK: begin
        program_counter_wren = 1'b1;
        rf_wren              = writes_rd_in_wb(opcode);
        w_state_next         = FETCH;
      end
      TRAP: begin
        trap_valid           = 1'b1;
        pc_select_trap       = 1'b1;
        program_counter_wren = 1'b1;
        w_state_next         = FETCH;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign trap_cause              = r_trap_cause;
  assign control_unit_state      = r_state;
  assign control_unit_state_next = w_state_next;

`ifdef RV32I_CU_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_cycles;
  logic [CNT_W-1:0] r_perf_instret;

  // Free-running cycle count and retire count (PC writes other than traps).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_cycles  <= '0;
      r_perf_instret <= '0;
    end else begin
      r_perf_cycles <= r_perf_cycles + CNT_W'(1);
      if (program_counter_wren && (r_state != TRAP)) begin
        r_perf_instret <= r_perf_instret + CNT_W'(1);
      end
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_rv32i_hs_control_unit.sv
// Bench for rv32i_hs_control_unit (BUS_TIMEOUT = 4). Each instruction is
// expanded from its class into the expected per-cycle trace; a table of
// hand-derived totals backs the directed cases, then random instructions
// with random handshake delays follow.
module tb_rv32i_hs_control_unit;
  import fe_pkg::*;

  localparam int TO = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  RV32I_OPCODE_t               opcode = R_TYPE;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic = MN_ADD;
  logic                        opcode_legal = 1'b1;
  logic                        bus_ack = 1'b0;
  logic                        exec_busy = 1'b0;
  logic bus_req, bus_rden, bus_wren, bus_addr_select_alu_out;
  logic ir_wren, rf_wren, program_counter_wren, pc_select_trap, trap_valid;
  RV32I_TRAP_CAUSE_t trap_cause;
  RV32I_CU_STATE_t   control_unit_state, control_unit_state_next;
`ifdef RV32I_CU_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_instret;
`endif

  always #5 clk = ~clk;

  rv32i_hs_control_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .opcode                  (opcode),
    .mnemonic                (mnemonic),
    .opcode_legal            (opcode_legal),
    .bus_ack                 (bus_ack),
    .exec_busy               (exec_busy),
    .bus_req                 (bus_req),
    .bus_rden                (bus_rden),
    .bus_wren                (bus_wren),
    .bus_addr_select_alu_out (bus_addr_select_alu_out),
    .ir_wren                 (ir_wren),
    .rf_wren                 (rf_wren),
    .program_counter_wren    (program_counter_wren),
    .pc_select_trap          (pc_select_trap),
    .trap_valid              (trap_valid),
    .trap_cause              (trap_cause),
    .control_unit_state      (control_unit_state),
    .control_unit_state_next (control_unit_state_next)
`ifdef RV32I_CU_PERF_CNT_EN
    ,
    .perf_cycles             (perf_cycles),
    .perf_instret            (perf_instret)
`endif
  );

  typedef struct packed {
    RV32I_CU_STATE_t   st;
    logic req, rd, wr, asel, ir, rf, pc, pt, tv;
    RV32I_TRAP_CAUSE_t cause;
  } obs_t;

  typedef struct {
    RV32I_OPCODE_t               opc;
    RV32I_INSTRUCTION_MNEMONIC_t mn;
    bit                          legal;
    int fw, bz, mw;
    int cyc, rf, pc, wr;
    RV32I_TRAP_CAUSE_t           cause;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int tag = 0;
  int n_cyc, n_rf, n_pc, n_wr;
  int g_cyc = 0;
  RV32I_TRAP_CAUSE_t exp_cause = TC_NONE;
  RV32I_CU_STATE_t   prev_next;
  bit                have_prev = 1'b0;

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t mk(input RV32I_CU_STATE_t s,
                              input bit req = 1'b0, input bit rd = 1'b0, input bit wr = 1'b0,
                              input bit asel = 1'b0, input bit ir = 1'b0, input bit rf = 1'b0,
                              input bit pc = 1'b0, input bit pt = 1'b0, input bit tv = 1'b0);
    obs_t o;
    o.st = s; o.req = req; o.rd = rd; o.wr = wr; o.asel = asel; o.ir = ir;
    o.rf = rf; o.pc = pc; o.pt = pt; o.tv = tv; o.cause = exp_cause;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = control_unit_state; o.req = bus_req; o.rd = bus_rden; o.wr = bus_wren;
    o.asel = bus_addr_select_alu_out; o.ir = ir_wren; o.rf = rf_wren;
    o.pc = program_counter_wren; o.pt = pc_select_trap; o.tv = trap_valid;
    o.cause = trap_cause;
    return o;
  endfunction

  task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h required %h", nm, tag, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d required %0d", nm, tag, got, exp);
    end
  endtask

  // One clock cycle: drive handshakes, sample mid-cycle, advance to next negedge.
  task automatic do_cycle(input string nm, input obs_t e, input bit ack, input bit busy);
    obs_t got;
    bus_ack = ack;
    exec_busy = busy;
    #1;
    if (have_prev) begin
      checks++;
      if (prev_next !== e.st) begin
        errors++;
        $display("FAIL state_next[%0d]: got %0d required %0d", tag, prev_next, e.st);
      end
    end
    got = sample();
    check_obs(nm, got, e);
    n_cyc++;
    n_rf += got.rf ? 1 : 0;
    n_pc += got.pc ? 1 : 0;
    n_wr += got.wr ? 1 : 0;
    prev_next = control_unit_state_next;
    have_prev = 1'b1;
    g_cyc++;
    @(negedge clk);
  endtask

  task automatic trap(input RV32I_TRAP_CAUSE_t c);
    exp_cause = c;
    do_cycle("trap", mk(TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), rnd(), rnd());
  endtask

  // Expected trace of one instruction, starting in FETCH.
  task automatic run_instr(input RV32I_OPCODE_t opc, input RV32I_INSTRUCTION_MNEMONIC_t mn,
                           input bit legal, input int fw, input int bz, input int mw);
    bit ack, ld, st, flow, link, wbrf;
    opcode = opc; mnemonic = mn; opcode_legal = legal;
    n_cyc = 0; n_rf = 0; n_pc = 0; n_wr = 0;
    ld   = (opc == I_LOAD_TYPE);
    st   = (opc == S_TYPE);
    flow = opc inside {B_TYPE, J_TYPE, I_JALR_TYPE, U_AUI_TYPE};
    link = mn inside {MN_JAL, MN_JALR, MN_AUIPC};
    wbrf = opc inside {R_TYPE, I_TYPE, I_LOAD_TYPE, U_LUI_TYPE};
    for (int k = 0; k < TO; k++) begin
      ack = (k == fw);
      do_cycle("fetch", mk(FETCH, 1'b1, 1'b1, 1'b0, 1'b0, ack), ack, rnd());
      if (ack) break;
      if (k == TO - 1) begin
        trap(TC_FETCH_TIMEOUT);
        return;
      end
    end
    do_cycle("decode", mk(DECODE), rnd(), rnd());
    if (!legal) begin
      trap(TC_ILLEGAL);
      return;
    end
    if (opc == I_ENV_TYPE) begin
      trap(TC_ECALL);
      return;
    end
    repeat (bz) do_cycle("exec_busy", mk(EXECUTE), rnd(), 1'b1);
    do_cycle("execute", mk(EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, flow && link, flow), rnd(), 1'b0);
    if (flow) return;
    if (ld || st) begin
      for (int k = 0; k < TO; k++) begin
        ack = (k == mw);
        do_cycle("mem", mk(MEM, 1'b1, ld, st, 1'b1, 1'b0, 1'b0, st && ack), ack, rnd());
        if (ack) break;
        if (k == TO - 1) begin
          trap(TC_MEM_TIMEOUT);
          return;
        end
      end
      if (st) return;
    end
    do_cycle("writeback", mk(WRITEBACK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wbrf, 1'b1), rnd(), rnd());
  endtask

  vec_t tbl[17];
  RV32I_OPCODE_t               r_opc[11];
  RV32I_INSTRUCTION_MNEMONIC_t r_mn[11];

  initial begin
    //        opc           mn         lg fw bz mw  cyc rf pc wr cause
    tbl = '{
      '{R_TYPE,       MN_ADD,    1'b1, 3, 0, 0,  7, 1, 1, 0, TC_NONE},
      '{S_TYPE,       MN_SW,     1'b1, 0, 0, 2,  6, 0, 1, 3, TC_NONE},
      '{I_LOAD_TYPE,  MN_LW,     1'b1, 1, 1, 0,  7, 1, 1, 0, TC_NONE},
      '{R_TYPE,       MN_ADD,    1'b1, 9, 0, 0,  5, 0, 1, 0, TC_FETCH_TIMEOUT},
      '{I_TYPE,       MN_ADDI,   1'b1, 3, 0, 0,  7, 1, 1, 0, TC_FETCH_TIMEOUT},
      '{I_ENV_TYPE,   MN_ECALL,  1'b1, 0, 0, 0,  3, 0, 1, 0, TC_ECALL},
      '{R_TYPE,       MN_ADD,    1'b0, 0, 0, 0,  3, 0, 1, 0, TC_ILLEGAL},
      '{I_ENV_TYPE,   MN_EBREAK, 1'b1, 0, 0, 0,  3, 0, 1, 0, TC_ECALL},
      '{R_TYPE,       MN_SUB,    1'b1, 0, 6, 0, 10, 1, 1, 0, TC_ECALL},
      '{J_TYPE,       MN_JAL,    1'b1, 0, 0, 0,  3, 1, 1, 0, TC_ECALL},
      '{B_TYPE,       MN_BEQ,    1'b1, 0, 0, 0,  3, 0, 1, 0, TC_ECALL},
      '{U_AUI_TYPE,   MN_AUIPC,  1'b1, 0, 0, 0,  3, 1, 1, 0, TC_ECALL},
      '{U_LUI_TYPE,   MN_LUI,    1'b1, 0, 0, 0,  4, 1, 1, 0, TC_ECALL},
      '{I_JALR_TYPE,  MN_JALR,   1'b1, 0, 0, 0,  3, 1, 1, 0, TC_ECALL},
      '{I_LOAD_TYPE,  MN_LW,     1'b1, 0, 0, 9,  8, 0, 1, 0, TC_MEM_TIMEOUT},
      '{S_TYPE,       MN_SB,     1'b1, 0, 0, 3,  7, 0, 1, 4, TC_MEM_TIMEOUT},
      '{I_FENCE_TYPE, MN_FENCE,  1'b1, 0, 0, 0,  4, 0, 1, 0, TC_MEM_TIMEOUT}
    };
    r_opc = '{R_TYPE, I_TYPE, I_LOAD_TYPE, S_TYPE, B_TYPE, J_TYPE, I_JALR_TYPE,
              U_LUI_TYPE, U_AUI_TYPE, I_ENV_TYPE, I_FENCE_TYPE};
    r_mn  = '{MN_ADD, MN_ADDI, MN_LW, MN_SW, MN_BEQ, MN_JAL, MN_JALR,
              MN_LUI, MN_AUIPC, MN_ECALL, MN_FENCE};

    // Reset: everything idle and zero, cause cleared.
    #1;
    check_obs("reset", sample(), mk(IDLE));
`ifdef RV32I_CU_PERF_CNT_EN
    check_int("perf_reset", int'(perf_cycles) + int'(perf_instret), 0);
`endif
    repeat (2) @(negedge clk);
    check_obs("reset_hold", sample(), mk(IDLE));
    rst = 1'b1;
    do_cycle("idle", mk(IDLE), rnd(), rnd());

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      tag = i;
      run_instr(tbl[i].opc, tbl[i].mn, tbl[i].legal, tbl[i].fw, tbl[i].bz, tbl[i].mw);
      check_int("cycles", n_cyc, tbl[i].cyc);
      check_int("rf_pulses", n_rf, tbl[i].rf);
      check_int("pc_pulses", n_pc, tbl[i].pc);
      check_int("wren_cycles", n_wr, tbl[i].wr);
      check_int("cause", int'(trap_cause), int'(tbl[i].cause));
    end

    // Reset in the middle of a store: strobes must drop without a clock.
    tag = 100;
    opcode = S_TYPE; mnemonic = MN_SW; opcode_legal = 1'b1;
    do_cycle("fetch", mk(FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    do_cycle("decode", mk(DECODE), 1'b0, 1'b0);
    do_cycle("execute", mk(EXECUTE), 1'b0, 1'b0);
    do_cycle("mem", mk(MEM, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    do_cycle("mem", mk(MEM, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    exp_cause = TC_NONE;
    check_obs("rst_mid_mem", sample(), mk(IDLE));
    @(negedge clk);
    rst = 1'b1;
    have_prev = 1'b0;
    do_cycle("idle", mk(IDLE), rnd(), rnd());

    // Random instructions and handshake timing.
    for (int i = 0; i < 40; i++) begin
      int p;
      tag = 200 + i;
      p = int'($urandom_range(0, 10));
      run_instr(r_opc[p], r_mn[p], ($urandom_range(0, 7) != 0),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
    end

`ifdef RV32I_CU_PERF_CNT_EN
    begin
      logic [31:0] c0, i0;
      int          g0;
      tag = 300;
      c0 = perf_cycles; i0 = perf_instret; g0 = g_cyc;
      repeat (3) run_instr(R_TYPE, MN_ADD, 1'b1, 0, 0, 0);
      run_instr(R_TYPE, MN_ADD, 1'b0, 0, 0, 0);
      check_int("perf_instret", int'(perf_instret - i0), 3);
      check_int("perf_cycles", int'(perf_cycles - c0), g_cyc - g0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
